// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between N_CORES cores.
// One transaction at a time: IDLE (arbitrate) -> BUSY (wait for memory or
// timeout) -> DONE (one-cycle response to the granted core) -> IDLE.
module mem_arbiter #(
  parameter int N_CORES = 2,
  parameter int ID_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CORES-1:0]     core_request,
  input  logic [32*N_CORES-1:0]  core_addr,
  input  logic [N_CORES-1:0]     core_rden,
  input  logic [N_CORES-1:0]     core_wren,
  input  logic [32*N_CORES-1:0]  core_write_val,
  output logic [N_CORES-1:0]     core_enable,
  output logic [31:0]            core_read_val,
  output logic [N_CORES-1:0]     core_response,
  output logic [31:0]            mem_addr,
  output logic                   mem_rden,
  output logic                   mem_wren,
  output logic [31:0]            mem_write_val,
  input  logic [31:0]            mem_read_val,
  input  logic                   mem_response,
  output logic                   err_timeout,
  output logic [ID_W-1:0]        err_id
);

  localparam int unsigned NC    = N_CORES;
  localparam int          CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [N_CORES-1:0] ONE = N_CORES'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_err_id;
  logic [ID_W-1:0]   w_winner;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_rden;
  logic              r_wren;
  logic              r_tflag;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_any;
  logic              w_cnt_max;
  logic [N_CORES-1:0] w_onehot;
  logic [31:0]       w_addr_arr  [N_CORES];
  logic [31:0]       w_wdata_arr [N_CORES];

  for (genvar g = 0; g < N_CORES; g++) begin : g_split
    assign w_addr_arr[g]  = core_addr[32*g +: 32];
    assign w_wdata_arr[g] = core_write_val[32*g +: 32];
  end

  assign w_any     = |core_request;
  assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_onehot  = ONE << r_grant;

  // Round-robin pick: first requester after the last grant, wrapping around.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    w_winner = r_last;
    for (int unsigned i = 1; i <= NC; i++) begin
      idx = (32'(r_last) + i) % NC;
      if (!found && core_request[ID_W'(idx)]) begin
        w_winner = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a response on the final timeout cycle still counts as a response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (mem_response || w_cnt_max) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction datapath: latch winner's request, count BUSY cycles, capture result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant  <= '0;
      r_last   <= ID_W'(N_CORES - 1);
      r_err_id <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rden   <= 1'b0;
      r_wren   <= 1'b0;
      r_tflag  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_addr  <= w_addr_arr[w_winner];
            r_wdata <= w_wdata_arr[w_winner];
            r_wren  <= core_wren[w_winner];
            r_rden  <= core_rden[w_winner] & ~core_wren[w_winner];
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_response) begin
            r_rdata <= mem_read_val;
          end else if (w_cnt_max) begin
            r_rdata  <= 32'hDEAD_BEEF;
            r_tflag  <= 1'b1;
            r_err_id <= r_grant;
          end
        end
        S_DONE: begin
          r_last  <= r_grant;
          r_tflag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so enables drop as soon as reset asserts.
  always_comb begin
    core_enable   = '0;
    core_response = '0;
    mem_rden      = 1'b0;
    mem_wren      = 1'b0;
    err_timeout   = 1'b0;
    core_read_val = r_rdata;
    mem_addr      = r_addr;
    mem_write_val = r_wdata;
    err_id        = r_err_id;
    case (r_state)
      S_BUSY: begin
        core_enable = w_onehot;
        mem_rden    = r_rden;
        mem_wren    = r_wren;
      end
      S_DONE: begin
        core_enable   = w_onehot;
        core_response = w_onehot;
        err_timeout   = r_tflag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with two cores.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  core_request;
  logic [63:0] core_addr;
  logic [1:0]  core_rden;
  logic [1:0]  core_wren;
  logic [63:0] core_write_val;
  logic [1:0]  core_enable;
  logic [31:0] core_read_val;
  logic [1:0]  core_response;
  logic [31:0] mem_addr;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val;
  logic        mem_response;
  logic        err_timeout;
  logic [0:0]  err_id;

  int n_vec  = 0;
  int n_miss = 0;

  mem_arbiter #(.N_CORES(2), .TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_request   (core_request),
    .core_addr      (core_addr),
    .core_rden      (core_rden),
    .core_wren      (core_wren),
    .core_write_val (core_write_val),
    .core_enable    (core_enable),
    .core_read_val  (core_read_val),
    .core_response  (core_response),
    .mem_addr       (mem_addr),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_write_val  (mem_write_val),
    .mem_read_val   (mem_read_val),
    .mem_response   (mem_response),
    .err_timeout    (err_timeout),
    .err_id         (err_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b0;
    core_request   = '0;
    core_addr      = '0;
    core_rden      = '0;
    core_wren      = '0;
    core_write_val = '0;
    mem_read_val   = '0;
    mem_response   = 1'b0;
    #3;
    chk("rst_enable",   32'(core_enable),   32'h0);
    chk("rst_response", 32'(core_response), 32'h0);
    chk("rst_rden",     32'(mem_rden),      32'h0);
    chk("rst_wren",     32'(mem_wren),      32'h0);
    chk("rst_rdval",    core_read_val,      32'h0);
    chk("rst_errto",    32'(err_timeout),   32'h0);
    step();
    reset = 1'b1;
    step();

    // Single read from core0, memory answers after two BUSY cycles.
    core_request = 2'b01;
    core_rden    = 2'b01;
    core_addr    = {32'h0000_0200, 32'h0000_0010};
    step();
    chk("rd_busy1_rden", 32'(mem_rden),    32'h1);
    chk("rd_busy1_addr", mem_addr,         32'h10);
    chk("rd_busy1_en",   32'(core_enable), 32'h1);
    chk("rd_busy1_resp", 32'(core_response), 32'h0);
    step();
    chk("rd_busy2_rden", 32'(mem_rden),    32'h1);
    chk("rd_busy2_addr", mem_addr,         32'h10);
    mem_response = 1'b1;
    mem_read_val = 32'hCAFE_F00D;
    step();
    mem_response = 1'b0;
    core_request = 2'b00;
    chk("rd_done_resp",  32'(core_response), 32'h1);
    chk("rd_done_val",   core_read_val,      32'hCAFE_F00D);
    chk("rd_done_rden",  32'(mem_rden),      32'h0);
    chk("rd_done_en",    32'(core_enable),   32'h1);
    step();
    chk("rd_idle_resp",  32'(core_response), 32'h0);
    chk("rd_idle_en",    32'(core_enable),   32'h0);
    chk("rd_hold_val",   core_read_val,      32'hCAFE_F00D);

    // Both cores requesting continuously: grants alternate 0,1,0,1.
    do_reset();
    core_request = 2'b11;
    core_rden    = 2'b11;
    core_addr    = {32'h0000_0200, 32'h0000_0100};
    for (int t = 0; t < 4; t++) begin
      logic [31:0] g;
      g = 32'(t % 2);
      step();
      chk($sformatf("rr%0d_en", t),   32'(core_enable), 32'h1 << g);
      chk($sformatf("rr%0d_addr", t), mem_addr,         (g == 0) ? 32'h100 : 32'h200);
      chk($sformatf("rr%0d_rden", t), 32'(mem_rden),    32'h1);
      mem_read_val = 32'hA000 + 32'(t);
      mem_response = 1'b1;
      step();
      mem_response = 1'b0;
      if (t == 3) core_request = 2'b00;
      chk($sformatf("rr%0d_resp", t), 32'(core_response), 32'h1 << g);
      chk($sformatf("rr%0d_val", t),  core_read_val,      32'hA000 + 32'(t));
      step();
      chk($sformatf("rr%0d_idle", t), 32'(core_enable), 32'h0);
    end

    // Write from core1 with rden and wren both set: write wins.
    core_request   = 2'b10;
    core_rden      = 2'b10;
    core_wren      = 2'b10;
    core_addr      = {32'h0000_0020, 32'h0000_0010};
    core_write_val = {32'h1234_5678, 32'h0BAD_0BAD};
    step();
    chk("wr_wren", 32'(mem_wren),    32'h1);
    chk("wr_rden", 32'(mem_rden),    32'h0);
    chk("wr_wval", mem_write_val,    32'h1234_5678);
    chk("wr_addr", mem_addr,         32'h20);
    chk("wr_en",   32'(core_enable), 32'h2);
    mem_read_val = 32'h0000_0055;
    mem_response = 1'b1;
    step();
    mem_response = 1'b0;
    core_request = 2'b00;
    chk("wr_resp",      32'(core_response), 32'h2);
    chk("wr_done_wren", 32'(mem_wren),      32'h0);
    chk("wr_val",       core_read_val,      32'h55);
    step();

    // Timeout on core1: memory never answers.
    core_request = 2'b10;
    core_rden    = 2'b10;
    core_wren    = 2'b00;
    step();
    chk("to_en", 32'(core_enable), 32'h2);
    core_request = 2'b00;
    n = 0;
    while (core_response == 2'b00 && n < 200) begin
      step();
      n++;
    end
    chk("to_cycles", 32'(n),            32'd64);
    chk("to_resp",   32'(core_response), 32'h2);
    chk("to_val",    core_read_val,      32'hDEAD_BEEF);
    chk("to_err",    32'(err_timeout),   32'h1);
    chk("to_errid",  32'(err_id),        32'h1);
    step();
    chk("to_err_clr",  32'(err_timeout), 32'h0);
    chk("to_errid_hold", 32'(err_id),    32'h1);

    // Core0 drops its request during BUSY; transaction still completes.
    core_request = 2'b01;
    core_rden    = 2'b01;
    step();
    chk("drop_en", 32'(core_enable), 32'h1);
    core_request = 2'b00;
    step();
    step();
    mem_read_val = 32'h0000_A5A5;
    mem_response = 1'b1;
    step();
    mem_response = 1'b0;
    chk("drop_resp", 32'(core_response), 32'h1);
    chk("drop_val",  core_read_val,      32'hA5A5);
    chk("drop_err",  32'(err_timeout),   32'h0);
    step();

    // Reset asserted mid-BUSY drops enables without a clock edge.
    core_request = 2'b10;
    core_rden    = 2'b00;
    core_wren    = 2'b10;
    step();
    chk("mrst_pre_wren", 32'(mem_wren), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_wren", 32'(mem_wren),    32'h0);
    chk("mrst_rden", 32'(mem_rden),    32'h0);
    chk("mrst_en",   32'(core_enable), 32'h0);
    core_request = 2'b11;
    core_rden    = 2'b11;
    core_wren    = 2'b00;
    #3;
    reset = 1'b1;
    step();
    chk("mrst_first_en",   32'(core_enable), 32'h1);
    chk("mrst_first_addr", mem_addr,         32'h10);
    mem_read_val = 32'h0000_0777;
    mem_response = 1'b1;
    step();
    mem_response = 1'b0;
    core_request = 2'b00;
    chk("mrst_resp", 32'(core_response), 32'h1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit memory port between N_CORES core instances.
- Each core raises core_request and drives its addr/rden/wren/write_val; the arbiter grants one core via core_enable and runs one transaction to the memory.
- It returns read data with a one-cycle response pulse, then re-arbitrates.
- It sits between the Core instances and the DataMemory/top-level memory model.

Parameters:
- N_CORES, 2, number of requesters (2..8).
- ID_W, $clog2(N_CORES) (min 1), grant index width.
- TIMEOUT, 64, max cycles in BUSY waiting for mem_response before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- core_request  in  N_CORES  per-core transaction request.
- core_addr  in  32*N_CORES  per-core address; core i at bits [32i+31:32i].
- core_rden  in  N_CORES  per-core read enable.
- core_wren  in  N_CORES  per-core write enable.
- core_write_val  in  32*N_CORES  per-core write data.
- core_enable  out  N_CORES  one-hot grant.
- core_read_val  out  32  read data, shared by all cores; valid with core_response.
- core_response  out  N_CORES  one-cycle completion pulse to the granted core.
- mem_addr  out  32  memory address.
- mem_rden  out  1  memory read enable.
- mem_wren  out  1  memory write enable.
- mem_write_val  out  32  memory write data.
- mem_read_val  in  32  memory read data.
- mem_response  in  1  memory completion, sampled only in BUSY.
- err_timeout  out  1  one-cycle pulse in DONE when the transaction timed out.
- err_id  out  ID_W  core index of the last timeout; holds until the next timeout.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, all outputs 0.
  - last_grant=N_CORES-1, so core 0 wins first.
  - Internal registers cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any core_request bit is set, select the winner: first set bit scanning from last_grant+1 upward, wrapping modulo N_CORES.
  - On the next edge: state=BUSY, grant=winner, core_enable=one-hot(winner).
  - Also latch the winner's addr and write_val into mem_addr and mem_write_val.
  - Latch mem_wren=core_wren[w]; mem_rden=core_rden[w] & ~core_wren[w] (write wins if both are set).
  - If request is set with rden=wren=0, grant anyway; memory enables stay 0 and the transaction completes through timeout.
  - No request: remain in IDLE, outputs 0.
- BUSY:
  - mem_* held stable; wait counter increments each cycle starting from 0.
  - mem_response=1 → capture mem_read_val into rdata; on the next edge state=DONE.
  - counter==TIMEOUT-1 with no response → rdata=32'hDEAD_BEEF, set tflag; on the next edge state=DONE.
  - Deassertion of core_request by the granted core is ignored; the transaction completes.
- DONE (exactly 1 cycle):
  - mem_rden=mem_wren=0.
  - core_response[grant]=1; core_read_val=rdata (also for writes).
  - err_timeout=tflag; err_id=grant when tflag is set.
  - core_enable remains set.
  - Next edge: IDLE, last_grant=grant, core_enable=0, tflag cleared.
- Latency:
  - Uncontended: request seen at edge E → mem_* valid after E.
  - Response at edge R → core_response high during the cycle after R.
  - Minimum turnaround is 3 cycles per transaction: IDLE→BUSY→DONE→IDLE.
  - A core holding request continuously can be re-granted no sooner than the IDLE cycle after DONE, and only if no other core is pending.
- Fairness: with all N_CORES requesting continuously, grants rotate 0,1,..,N-1,0; no core waits more than N_CORES-1 transactions.
- core_read_val holds its last value outside DONE; consumers must qualify it with core_response.
- Reset asserted mid-BUSY: memory enables drop immediately (async); no response is issued; the pending transaction is lost.

Test Plan:
- Reset then single read:
  - Stimulus: core0 request, rden, addr=0x10; memory answers 0xCAFEF00D after 2 BUSY cycles.
  - Required: mem_rden=1 with addr 0x10 for 2 cycles; core_response=2'b01 for 1 cycle with core_read_val=0xCAFEF00D; core_enable returns to 0.
- Simultaneous requests:
  - Stimulus: core0 and core1 both request after reset.
  - Required: core0 granted first, then core1.
  - Stimulus: both held for 4 transactions.
  - Required: grant order 0,1,0,1.
- Write with rden and wren both set:
  - Stimulus: core1 addr=0x20, write_val=0x12345678, rden=wren=1.
  - Required: mem_wren=1, mem_rden=0, mem_write_val=0x12345678; core_response=2'b10.
- Timeout:
  - Stimulus: mem_response never asserted.
  - Required: after 64 BUSY cycles, DONE with core_response pulse, core_read_val=0xDEADBEEF, err_timeout=1, err_id=granted index.
- Reset mid-transaction:
  - Stimulus: assert reset during BUSY.
  - Required: mem_rden/mem_wren/core_enable go to 0 without waiting for a clock; after release, first grant goes to core0.
- Request drop:
  - Stimulus: core0 deasserts request during BUSY.
  - Required: transaction still completes and core_response[0] still pulses.
